// File: rtl/io_port.sv
// io_port: debounced user-input capture and 8-digit seven-segment display of a 32-bit value.
// Optional macro IO_PORT_SIGNED_DISPLAY_EN selects two's-complement display with a sign dash on HEX7.
`default_nettype none

module io_port #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        insert,
    input  logic [14:0] SW,
    input  logic [31:0] out_data,
    input  logic        output_flag,
    input  logic        input_flag,
    input  logic        halt,
    output logic [31:0] user_input,
    output logic        stall,
    output logic        busy,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7
);

    localparam int          CW        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_DASH  = 7'b0111111;
    localparam logic [6:0]  SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_IN = 2'd1,
        S_CONVERT = 2'd2,
        S_SHOW    = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           db_level_q, db_level_d;
    logic [CW-1:0]  db_cnt_q, db_cnt_d;
    logic           db_rise;
    logic [31:0]    bin_q, bin_d;
    logic [39:0]    bcd_q, bcd_d;
    logic [39:0]    bcd_adj;
    logic [4:0]     bit_cnt_q, bit_cnt_d;
    logic [55:0]    hex_q, hex_d;
    logic [31:0]    user_q, user_d;
    logic           too_big;
`ifdef IO_PORT_SIGNED_DISPLAY_EN
    logic           neg_q, neg_d;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [39:0] add3(input logic [39:0] bcd);
        logic [39:0] r;
        r = bcd;
        for (int i = 0; i < 10; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Scan from the top digit down; a digit is shown once any higher-or-equal digit is non-zero.
    function automatic logic [55:0] encode(input logic [39:0] bcd, input logic overflow);
        logic [55:0] r;
        logic        lead;
        r    = {8{SEG_DASH}};
        lead = 1'b0;
        if (!overflow) begin
            for (int i = 7; i >= 0; i--) begin
                lead = lead | (bcd[i*4 +: 4] != 4'd0);
                r[i*7 +: 7] = (lead || i == 0) ? seg7(bcd[i*4 +: 4]) : SEG_BLANK;
            end
        end
        return r;
    endfunction

    // A new level is adopted on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        db_rise    = 1'b0;
        if (insert != db_level_q) begin
            if (db_cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_level_d = insert;
                db_rise    = insert;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign bcd_adj = add3(bcd_q);

`ifdef IO_PORT_SIGNED_DISPLAY_EN
    assign too_big = neg_q ? (bcd_q[39:28] != 12'd0) : (bcd_q[39:32] != 8'd0);
`else
    assign too_big = (bcd_q[39:32] != 8'd0);
`endif

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        bit_cnt_d = bit_cnt_q;
        hex_d     = hex_q;
        user_d    = user_q;
`ifdef IO_PORT_SIGNED_DISPLAY_EN
        neg_d     = neg_q;
`endif
        if (!halt) begin
            case (state_q)
                S_IDLE: begin
                    if (output_flag) begin
`ifdef IO_PORT_SIGNED_DISPLAY_EN
                        neg_d = out_data[31];
                        bin_d = out_data[31] ? (~out_data + 32'd1) : out_data;
`else
                        bin_d = out_data;
`endif
                        bcd_d     = '0;
                        bit_cnt_d = '0;
                        state_d   = S_CONVERT;
                    end else if (input_flag) begin
                        state_d = S_WAIT_IN;
                    end
                end
                S_WAIT_IN: begin
                    if (db_rise) begin
                        user_d  = {17'b0, SW};
                        state_d = S_IDLE;
                    end
                end
                S_CONVERT: begin
                    {bcd_d, bin_d} = {bcd_adj[38:0], bin_q, 1'b0};
                    bit_cnt_d      = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd31)
                        state_d = S_SHOW;
                end
                S_SHOW: begin
                    hex_d = encode(bcd_q, too_big);
`ifdef IO_PORT_SIGNED_DISPLAY_EN
                    if (neg_q && !too_big)
                        hex_d[55:49] = SEG_DASH;
`endif
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            bit_cnt_q  <= '0;
            hex_q      <= {{7{SEG_BLANK}}, SEG_ZERO};
            user_q     <= '0;
`ifdef IO_PORT_SIGNED_DISPLAY_EN
            neg_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            bit_cnt_q  <= bit_cnt_d;
            hex_q      <= hex_d;
            user_q     <= user_d;
`ifdef IO_PORT_SIGNED_DISPLAY_EN
            neg_q      <= neg_d;
`endif
        end
    end

    assign user_input = user_q;
    assign stall      = (state_q == S_WAIT_IN);
    assign busy       = (state_q == S_CONVERT) || (state_q == S_SHOW);
    assign HEX0       = hex_q[6:0];
    assign HEX1       = hex_q[13:7];
    assign HEX2       = hex_q[20:14];
    assign HEX3       = hex_q[27:21];
    assign HEX4       = hex_q[34:28];
    assign HEX5       = hex_q[41:35];
    assign HEX6       = hex_q[48:42];
    assign HEX7       = hex_q[55:49];

endmodule

`default_nettype wire

// File: tb/tb_io_port.sv
// tb_io_port: directed and randomized checks of io_port display conversion, input capture, halt and reset.
`default_nettype none

module tb_io_port;

    localparam int         DB        = 4;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG [10]  = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                         7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                         7'b0000000, 7'b0010000};

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        insert = 1'b0;
    logic [14:0] SW = '0;
    logic [31:0] out_data = '0;
    logic        output_flag = 1'b0;
    logic        input_flag = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] user_input;
    logic        stall, busy;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
    logic [55:0] hex_obs;

    int tests = 0;
    int fails = 0;
    logic [55:0] prev_hex;
    logic [31:0] prev_user;
    logic [55:0] rst_hex;

    io_port #(.DEBOUNCE_CYCLES(DB)) dut (
        .CLK(CLK), .reset(reset), .insert(insert), .SW(SW), .out_data(out_data),
        .output_flag(output_flag), .input_flag(input_flag), .halt(halt),
        .user_input(user_input), .stall(stall), .busy(busy),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
        .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7)
    );

    always #5 CLK = ~CLK;

    assign hex_obs = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    // Expected display computed from the decimal value with plain arithmetic.
    function automatic logic [55:0] model_hex(input logic [31:0] v);
        longint      mag;
        int          ndig;
        bit          neg;
        logic [55:0] r;
        mag  = longint'(v);
        ndig = 8;
        neg  = 1'b0;
`ifdef IO_PORT_SIGNED_DISPLAY_EN
        if (v[31]) begin
            neg  = 1'b1;
            mag  = 64'd4294967296 - longint'(v);
            ndig = 7;
        end
`endif
        if (mag >= pow10(ndig)) return {8{SEG_DASH}};
        r = {8{SEG_BLANK}};
        for (int i = 0; i < ndig; i++) begin
            if (i == 0 || mag >= pow10(i))
                r[i*7 +: 7] = SEG[int'((mag / pow10(i)) % 10)];
        end
        if (neg) r[55:49] = SEG_DASH;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // One display request; optional halt window and an input_flag poke while busy.
    task automatic do_display(input logic [31:0] v, input int hs, input int hlen,
                              input bit poke, input bit both);
        int n;
        out_data    = v;
        output_flag = 1'b1;
        input_flag  = both;
        tick();
        output_flag = 1'b0;
        input_flag  = 1'b0;
        out_data    = $urandom;
        if (both) begin
            check("prio_busy", 64'(busy), 64'd1);
            check("prio_stall", 64'(stall), 64'd0);
        end
        n = 0;
        while (busy && n < 300) begin
            n++;
            input_flag = poke && (n == 5);
            if (hlen > 0 && n == hs) halt = 1'b1;
            if (hlen > 0 && n == hs + hlen) begin
                halt = 1'b0;
                check("halt_hex_held", 64'(hex_obs), 64'(prev_hex));
            end
            tick();
        end
        input_flag = 1'b0;
        check("busy_cycles", 64'(n), 64'(33 + hlen));
        prev_hex = model_hex(v);
        check("hex", 64'(hex_obs), 64'(prev_hex));
        if (poke) check("ignored_in_busy", 64'(stall), 64'd0);
    endtask

    task automatic do_input(input logic [14:0] sw, input int npulse);
        SW         = sw;
        input_flag = 1'b1;
        tick();
        input_flag = 1'b0;
        check("stall_rise", 64'(stall), 64'd1);
        for (int k = 0; k < npulse; k++) begin
            insert = 1'b1;
            repeat ($urandom_range(1, DB - 1)) tick();
            insert = 1'b0;
            repeat (2) tick();
        end
        check("short_stall", 64'(stall), 64'd1);
        check("short_user", 64'(user_input), 64'(prev_user));
        insert = 1'b1;
        repeat (DB - 1) tick();
        check("stall_before_accept", 64'(stall), 64'd1);
        tick();
        prev_user = {17'b0, sw};
        check("stall_after", 64'(stall), 64'd0);
        check("user_input", 64'(user_input), 64'(prev_user));
        insert = 1'b0;
        repeat (DB + 1) tick();
    endtask

    initial begin
        logic [31:0] v;
        rst_hex   = {{7{SEG_BLANK}}, SEG[0]};
        prev_hex  = rst_hex;
        prev_user = '0;

        #12;
        check("rst_hex", 64'(hex_obs), 64'(rst_hex));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_user", 64'(user_input), 64'd0);
        @(negedge CLK);
        reset = 1'b0;
        tick();

        do_display(32'd1234, 0, 0, 1'b0, 1'b0);
        do_display(32'd0, 0, 0, 1'b0, 1'b0);
        do_display(32'd100000000, 0, 0, 1'b0, 1'b0);
        do_display(32'd99999999, 0, 0, 1'b0, 1'b0);
        do_display(32'hFFFFFFFB, 0, 0, 1'b0, 1'b0);
        do_display(32'h80000000, 0, 0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            case (k % 4)
                0: v = $urandom;
                1: v = $urandom_range(0, 99999999);
                2: v = $urandom_range(0, 9999);
                default: v = 32'd0 - $urandom_range(1, 9999999);
            endcase
            do_display(v, $urandom_range(2, 30), (k % 2) * $urandom_range(1, 6), k == 3, 1'b0);
        end

        do_input(15'h1234, 0);
        do_input(15'($urandom), 3);

        insert = 1'b1;
        repeat (DB + 1) tick();
        check("held_idle_stall", 64'(stall), 64'd0);
        SW         = 15'($urandom);
        input_flag = 1'b1;
        tick();
        input_flag = 1'b0;
        repeat (10) tick();
        check("held_stall", 64'(stall), 64'd1);
        check("held_user", 64'(user_input), 64'(prev_user));
        insert = 1'b0;
        repeat (DB + 1) tick();
        insert = 1'b1;
        repeat (DB) tick();
        prev_user = {17'b0, SW};
        check("held_stall_after", 64'(stall), 64'd0);
        check("held_user_after", 64'(user_input), 64'(prev_user));
        insert = 1'b0;
        repeat (DB + 1) tick();

        out_data    = 32'd87654321;
        output_flag = 1'b1;
        tick();
        output_flag = 1'b0;
        repeat (9) tick();
        #2 reset = 1'b1;
        #1;
        check("abort_hex", 64'(hex_obs), 64'(rst_hex));
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_user", 64'(user_input), 64'd0);
        @(negedge CLK);
        reset     = 1'b0;
        prev_hex  = rst_hex;
        prev_user = '0;
        tick();
        do_display(32'd7, 0, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/io_port.md
IO_PORT -- requirements
Module: io_port

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required to accept an insert level change.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 insert  input  1  raw user-confirm button, active-high, may bounce.
REQ-005 SW  input  15  user data switches.
REQ-006 out_data  input  32  value to display (register rs read data).
REQ-007 output_flag  input  1  display request from control unit.
REQ-008 input_flag  input  1  input request from control unit.
REQ-009 halt  input  1  processor halted.
REQ-010 user_input  output  32  captured input value.
REQ-011 stall  output  1  high while an input request waits for user confirmation.
REQ-012 busy  output  1  high while a display conversion is in progress.
REQ-013 HEX0..HEX7  output  7 each  active-low seven-segment digits, HEX0 least significant.

Function
REQ-014 FSM states: IDLE, WAIT_IN, CONVERT, SHOW; SHOW lasts one cycle, then returns to IDLE.
REQ-015 IDLE + output_flag: out_data captured, -> CONVERT; output_flag takes priority if both flags are high.
REQ-016 IDLE + input_flag (no output_flag): -> WAIT_IN; stall high from the next cycle.
REQ-017 Debouncer: insert accepted as a new level only after DEBOUNCE_CYCLES consecutive equal samples; shorter pulses are ignored.
REQ-018 WAIT_IN + debounced rising edge of insert: user_input = {17'b0, SW} sampled on that cycle; stall low on the following cycle; -> IDLE.
REQ-019 Debounced insert edges outside WAIT_IN: ignored; a button held across entry into WAIT_IN must be released and pressed again.
REQ-020 CONVERT: sequential shift-add-3 binary-to-BCD, one bit per cycle, 32 cycles, 10 BCD digits; busy high throughout CONVERT and SHOW.
REQ-021 Latency: capture edge N; HEX outputs update on edge N+33; busy low from edge N+33.
REQ-022 Requests arriving while busy or stall is high are ignored; the control unit holds its flag until it is accepted.
REQ-023 Segment codes 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000; blank = 1111111; dash = 0111111.
REQ-024 Leading zeros are blanked; HEX0 always shows a digit (value 0 shows 0 on HEX0 only).
REQ-025 Value > 99,999,999 (BCD digit 8 or 9 non-zero): all HEX show dash.
REQ-026 halt high: FSM frozen in its current state, HEX and user_input held; resumes on halt low.

Reset
REQ-027 On reset, asynchronously: state IDLE, user_input = 0, stall = 0, busy = 0, HEX0 = 1000000, HEX1..HEX7 = blank, debouncer cleared to released.
REQ-028 Reset during CONVERT or WAIT_IN aborts the operation; no partial result reaches HEX or user_input.

Configuration
REQ-029 Macro IO_PORT_SIGNED_DISPLAY_EN defined: out_data is two's complement; if negative, the magnitude is converted, HEX7 = dash as sign, and magnitudes > 9,999,999 show all dashes.
REQ-030 Macro undefined: out_data is unsigned and displayed over 8 digits per REQ-025; no sign logic is present.

Verification
REQ-031 out_data = 1234, output_flag pulse -> busy high for 33 cycles, then HEX3..HEX0 = 1111001, 0100100, 0110000, 0011001, HEX4..HEX7 blank.
REQ-032 out_data = 0 -> HEX0 = 1000000, others blank; out_data = 100,000,000 -> all HEX = 0111111.
REQ-033 input_flag, SW = 15'h1234, insert high for 4 cycles -> stall high until the accepted edge, then user_input = 32'h00001234, stall low.
REQ-034 insert pulses of 2 cycles during WAIT_IN -> no capture, stall remains high.
REQ-035 out_data = 32'hFFFFFFFB: with macro -> HEX7 = dash, HEX0 = 0010010, HEX1..HEX6 blank; without macro -> all dashes.
REQ-036 Reset asserted on cycle 10 of CONVERT -> immediate reset values, and a subsequent request for 7 displays 1111000 on HEX0.
